// File: rtl/fetch_queue_pkg.sv
// Shared widths and opcode-class constants for the prefetch path and decoder.
package fetch_queue_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int REG_WIDTH  = 8;
    localparam int FQ_DEPTH   = 4;
    localparam int LEN_WIDTH  = 2;

    // Implied/stack opcodes that break the nibble-based length rules.
    localparam logic [REG_WIDTH-1:0] OPC_BRK = 8'h00;
    localparam logic [REG_WIDTH-1:0] OPC_JSR = 8'h20;
    localparam logic [REG_WIDTH-1:0] OPC_RTI = 8'h40;
    localparam logic [REG_WIDTH-1:0] OPC_RTS = 8'h60;

    typedef logic [LEN_WIDTH-1:0] len_t;

endpackage

// File: rtl/fetch_queue_opcode_len.sv
// Combinational opcode-to-instruction-length decoder (1..3 bytes).
module opcode_len
    import fetch_queue_pkg::*;
#(
    parameter int DATA_WIDTH = fetch_queue_pkg::REG_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] opcode,
    output logic [LEN_WIDTH-1:0]  len
);

    always_comb begin
        len = LEN_WIDTH'(2);
        if (opcode == DATA_WIDTH'(OPC_JSR)) begin
            len = LEN_WIDTH'(3);
        end else if (opcode == DATA_WIDTH'(OPC_BRK) || opcode == DATA_WIDTH'(OPC_RTI) ||
                     opcode == DATA_WIDTH'(OPC_RTS)) begin
            len = LEN_WIDTH'(1);
        end else if (opcode[3:2] == 2'b11) begin
            len = LEN_WIDTH'(3);
        end else if (opcode[3:0] == 4'h9 && opcode[4]) begin
            len = LEN_WIDTH'(3);
        end else if (opcode[3:0] == 4'h8 || opcode[3:0] == 4'hA) begin
            len = LEN_WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential byte reads ahead of execution, whole
// instructions handed to the decoder by valid/ready, redirect flushes and restarts.
module fetch_queue #(
    parameter int ADDR_WIDTH = fetch_queue_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = fetch_queue_pkg::REG_WIDTH,
    parameter int DEPTH      = fetch_queue_pkg::FQ_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 16'hC000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    rdy,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_rd,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    input  logic                    redirect,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [DATA_WIDTH-1:0]   instr_opcode,
    output logic [DATA_WIDTH-1:0]   instr_op0,
    output logic [DATA_WIDTH-1:0]   instr_op1,
    output logic [1:0]              instr_len,
    output logic [ADDR_WIDTH-1:0]   instr_pc,
    output logic [$clog2(DEPTH):0]  fill_level
);

    import fetch_queue_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CRD_W = CNT_W + 1;

    localparam logic [0:0] REQ_IDLE = 1'b0;
    localparam logic [0:0] REQ_WAIT = 1'b1;

    logic [DATA_WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] pc;
    logic [0:0]            req_state;
    logic [DATA_WIDTH-1:0] head_byte;
    logic [LEN_WIDTH-1:0]  head_len;
    logic                  push;
    logic                  pop;
    logic                  credit;

    // Credit uses the registered count, so a same-cycle pop frees space one cycle later.
    assign credit = (CRD_W'(count) + CRD_W'(req_state)) < CRD_W'(DEPTH);
    assign mem_rd = reset_n && rdy && !redirect && credit;
    assign push   = (req_state == REQ_WAIT) && !redirect;
    assign pop    = instr_valid && instr_ready && !redirect;

    always_ff @(posedge clk) begin
        if (push) begin
            store[tail] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            fetch_pc  <= RESET_PC;
            pc        <= RESET_PC;
            req_state <= REQ_IDLE;
        end else if (redirect) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            fetch_pc  <= redirect_pc;
            pc        <= redirect_pc;
            req_state <= REQ_IDLE;
        end else begin
            req_state <= mem_rd ? REQ_WAIT : REQ_IDLE;
            if (mem_rd) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
            end
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(head_len);
                pc   <= pc + ADDR_WIDTH'(head_len);
            end
            count <= count + CNT_W'(push) - (pop ? CNT_W'(head_len) : '0);
        end
    end

    // An empty queue presents a zero head byte, which decodes to length 1.
    assign head_byte = (count != '0) ? store[head] : '0;

    opcode_len #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_opcode_len (
        .opcode(head_byte),
        .len   (head_len)
    );

    assign instr_valid  = count >= CNT_W'(head_len);
    assign instr_opcode = head_byte;
    assign instr_op0    = (head_len >= LEN_WIDTH'(2)) ? store[head + PTR_W'(1)] : '0;
    assign instr_op1    = (head_len == LEN_WIDTH'(3)) ? store[head + PTR_W'(2)] : '0;
    assign instr_len    = head_len;
    assign instr_pc     = pc;
    assign mem_addr     = fetch_pc;
    assign fill_level   = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: two instances (default and wrap-around reset PC).
module tb_fetch_queue;

    typedef struct packed {
        logic [7:0]  opc;
        logic [7:0]  op0;
        logic [7:0]  op1;
        logic [1:0]  len;
        logic [15:0] pc;
    } instr_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        rdy_a, redirect_a, ready_a, mem_rd_a, valid_a;
    logic [15:0] addr_a, redirect_pc_a, pc_a;
    logic [7:0]  data_a, opc_a, op0_a, op1_a;
    logic [1:0]  len_a;
    logic [2:0]  fill_a;

    logic        rdy_b, redirect_b, ready_b, mem_rd_b, valid_b;
    logic [15:0] addr_b, redirect_pc_b, pc_b;
    logic [7:0]  data_b, opc_b, op0_b, op1_b;
    logic [1:0]  len_b;
    logic [2:0]  fill_b;

    fetch_queue #(.DEPTH(4), .RESET_PC(16'hC000)) dut_a (
        .clk(clk), .reset_n(reset_n), .rdy(rdy_a), .mem_addr(addr_a), .mem_rd(mem_rd_a),
        .mem_data(data_a), .redirect(redirect_a), .redirect_pc(redirect_pc_a),
        .instr_valid(valid_a), .instr_ready(ready_a), .instr_opcode(opc_a),
        .instr_op0(op0_a), .instr_op1(op1_a), .instr_len(len_a), .instr_pc(pc_a),
        .fill_level(fill_a)
    );

    fetch_queue #(.DEPTH(4), .RESET_PC(16'hFFFE)) dut_b (
        .clk(clk), .reset_n(reset_n), .rdy(rdy_b), .mem_addr(addr_b), .mem_rd(mem_rd_b),
        .mem_data(data_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
        .instr_valid(valid_b), .instr_ready(ready_b), .instr_opcode(opc_b),
        .instr_op0(op0_b), .instr_op1(op1_b), .instr_len(len_b), .instr_pc(pc_b),
        .fill_level(fill_b)
    );

    logic [7:0] mem_img [65536];
    always @(posedge clk) begin
        if (mem_rd_a) data_a <= mem_img[addr_a];
        if (mem_rd_b) data_b <= mem_img[addr_b];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_pop_a  = 0;
    int n_pop_b  = 0;
    instr_t      exp_a[$];
    instr_t      exp_b[$];
    logic [15:0] exp_addr_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_instr(input string tag, input instr_t got, input instr_t exp);
        check({tag, ".opcode"}, 32'(got.opc), 32'(exp.opc));
        check({tag, ".op0"},    32'(got.op0), 32'(exp.op0));
        check({tag, ".op1"},    32'(got.op1), 32'(exp.op1));
        check({tag, ".len"},    32'(got.len), 32'(exp.len));
        check({tag, ".pc"},     32'(got.pc),  32'(exp.pc));
    endtask

    // Monitors: compare every accepted instruction / issued read against the queues.
    always @(negedge clk) begin
        if (reset_n && valid_a && ready_a && !redirect_a) begin
            n_pop_a++;
            if (exp_a.size() == 0) check("unexpected_pop_a", 32'(pc_a), 32'hFFFF_FFFF);
            else check_instr("a", {opc_a, op0_a, op1_a, len_a, pc_a}, exp_a.pop_front());
        end
        if (reset_n && valid_b && ready_b && !redirect_b) begin
            n_pop_b++;
            if (exp_b.size() == 0) check("unexpected_pop_b", 32'(pc_b), 32'hFFFF_FFFF);
            else check_instr("b", {opc_b, op0_b, op1_b, len_b, pc_b}, exp_b.pop_front());
        end
        if (reset_n && mem_rd_b && exp_addr_b.size() != 0)
            check("addr_b", 32'(addr_b), 32'(exp_addr_b.pop_front()));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1);
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, ".mem_rd"}, 32'(mem_rd_a), 0);
        check({tag, ".mem_addr"}, 32'(addr_a), 32'hC000);
        check({tag, ".valid"}, 32'(valid_a), 0);
        check({tag, ".opcode"}, 32'(opc_a), 0);
        check({tag, ".op0"}, 32'(op0_a), 0);
        check({tag, ".op1"}, 32'(op1_a), 0);
        check({tag, ".len"}, 32'(len_a), 1);
        check({tag, ".pc"}, 32'(pc_a), 32'hC000);
        check({tag, ".fill"}, 32'(fill_a), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        for (int i = 0; i < 65536; i++) mem_img[i] = 8'hEA;
        mem_img[16'hC000] = 8'hA9; mem_img[16'hC001] = 8'h42; mem_img[16'hC002] = 8'h8D;
        mem_img[16'hC003] = 8'h00; mem_img[16'hC004] = 8'h02; mem_img[16'hC005] = 8'hEA;
        mem_img[16'hFFFE] = 8'h4C; mem_img[16'hFFFF] = 8'h00; mem_img[16'h0000] = 8'h80;
        mem_img[16'h1234] = 8'h60; mem_img[16'h1235] = 8'hA2; mem_img[16'h1236] = 8'h05;

        reset_n = 1'b0;
        rdy_a = 1'b1; redirect_a = 1'b0; redirect_pc_a = '0; ready_a = 1'b0;
        rdy_b = 1'b1; redirect_b = 1'b0; redirect_pc_b = '0; ready_b = 1'b0;
        cyc(2);
        check_reset_a("reset_a");
        check("reset_b.mem_addr", 32'(addr_b), 32'hFFFE);
        check("reset_b.pc", 32'(pc_b), 32'hFFFE);
        check("reset_b.mem_rd", 32'(mem_rd_b), 0);

        // Wrap-around fetch on instance b while instance a fills with no consumer.
        exp_addr_b.push_back(16'hFFFE);
        exp_addr_b.push_back(16'hFFFF);
        exp_addr_b.push_back(16'h0000);
        exp_b.push_back('{8'h4C, 8'h00, 8'h80, 2'd3, 16'hFFFE});
        ready_b = 1'b1;
        reset_n = 1'b1;
        for (int i = 0; i < 40 && n_pop_b < 1; i++) cyc(1);
        ready_b = 1'b0;
        check("wrap.pops", 32'(n_pop_b), 1);
        check("wrap.next_pc", 32'(pc_b), 32'h0001);

        // Full queue: no requests, outputs frozen on head A9.
        cyc(3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full.mem_rd", 32'(mem_rd_a), 0);
            check("full.fill", 32'(fill_a), 4);
            check("full.valid", 32'(valid_a), 1);
            check_instr("full", {opc_a, op0_a, op1_a, len_a, pc_a},
                        '{8'hA9, 8'h42, 8'h00, 2'd2, 16'hC000});
            cyc(1);
        end

        // Drain the first three instructions.
        exp_a.push_back('{8'hA9, 8'h42, 8'h00, 2'd2, 16'hC000});
        exp_a.push_back('{8'h8D, 8'h00, 8'h02, 2'd3, 16'hC002});
        exp_a.push_back('{8'hEA, 8'h00, 8'h00, 2'd1, 16'hC005});
        base = n_pop_a;
        ready_a = 1'b1;
        for (int i = 0; i < 40 && n_pop_a < base + 3; i++) cyc(1);
        ready_a = 1'b0;
        check("drain.pops", 32'(n_pop_a - base), 3);

        // rdy low with one read outstanding.
        do_reset();
        cyc(1);
        rdy_a = 1'b0;
        @(negedge clk);
        check("rdy0.mem_rd_first", 32'(mem_rd_a), 0);
        check("rdy0.fill_first", 32'(fill_a), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            @(negedge clk);
            check("rdy0.mem_rd", 32'(mem_rd_a), 0);
            check("rdy0.fill", 32'(fill_a), 1);
        end
        cyc(1);
        rdy_a = 1'b1;
        @(negedge clk);
        check("rdy1.mem_rd", 32'(mem_rd_a), 1);
        check("rdy1.mem_addr", 32'(addr_a), 32'hC001);

        // Redirect in the cycle the C003 byte returns.
        do_reset();
        cyc(4);
        redirect_a = 1'b1;
        redirect_pc_a = 16'h1234;
        @(negedge clk);
        check("redir.fill_before", 32'(fill_a), 3);
        check("redir.mem_rd", 32'(mem_rd_a), 0);
        exp_a.push_back('{8'h60, 8'h00, 8'h00, 2'd1, 16'h1234});
        exp_a.push_back('{8'hA2, 8'h05, 8'h00, 2'd2, 16'h1235});
        base = n_pop_a;
        cyc(1);
        redirect_a = 1'b0;
        ready_a = 1'b1;
        @(negedge clk);
        check("redir.fill_after", 32'(fill_a), 0);
        check("redir.valid_after", 32'(valid_a), 0);
        check("redir.mem_rd_next", 32'(mem_rd_a), 1);
        check("redir.mem_addr_next", 32'(addr_a), 32'h1234);
        cyc(1);
        @(negedge clk);
        check("redir.valid_plus1", 32'(valid_a), 0);
        cyc(1);
        @(negedge clk);
        check("redir.valid_plus2", 32'(valid_a), 1);
        for (int i = 0; i < 40 && n_pop_a < base + 2; i++) cyc(1);
        ready_a = 1'b0;
        check("redir.pops", 32'(n_pop_a - base), 2);

        // Asynchronous reset pulse mid-cycle while filling.
        cyc(2);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_a("async");
        check("async_b.mem_addr", 32'(addr_b), 32'hFFFE);
        cyc(1);
        reset_n = 1'b1;
        @(negedge clk);
        check("async.restart_rd", 32'(mem_rd_a), 1);
        check("async.restart_addr", 32'(addr_a), 32'hC000);
        exp_a.push_back('{8'hA9, 8'h42, 8'h00, 2'd2, 16'hC000});
        base = n_pop_a;
        cyc(1);
        ready_a = 1'b1;
        for (int i = 0; i < 40 && n_pop_a < base + 1; i++) cyc(1);
        ready_a = 1'b0;
        check("async.pops", 32'(n_pop_a - base), 1);

        cyc(2);
        check("left_exp_a", 32'(exp_a.size()), 0);
        check("left_exp_b", 32'(exp_b.size()), 0);
        check("left_addr_b", 32'(exp_addr_b.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
